// File: rtl/bus_timer_slave.sv
// bus_timer_slave: machine-timer target on the core bus.
// Holds a free-running 64-bit mtime and a 64-bit mtimecmp, answers
// word-wide reads/writes with a single-cycle ack after an optional
// fixed number of wait states, and drives the timer-interrupt line.
//
// Handshake: a request is i_bus_en=1 with i_addr inside the 16-byte
// window; the master holds address/data/controls stable until it sees
// o_ack, which pulses for exactly one cycle. i_bus_en is ignored during
// the ack cycle, so a request still present in the following cycle is
// treated as a new transfer.
module bus_timer_slave #(
   parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned PRESCALE    = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_bus_en,
   input  logic        i_wr_en,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wr_data,
   input  logic [3:0]  i_byte_en,
   output logic        o_ack,
   output logic [31:0] o_rd_data,
   output logic        o_tip,
   output logic [1:0]  o_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   localparam logic [3:0] WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam int         PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

   state_t        state, state_nxt;
   logic [3:0]    wait_cnt, wait_cnt_nxt;

   logic [1:0]    lat_off;
   logic          lat_wr;
   logic [31:0]   lat_data;
   logic [3:0]    lat_be;

   logic          sel;
   logic          commit;
   logic [1:0]    cmt_off;
   logic          cmt_wr;
   logic [31:0]   cmt_data;
   logic [3:0]    cmt_be;

   logic [63:0]   mtime;
   logic [63:0]   mtimecmp;
   logic [PW-1:0] pre_cnt;
   logic          tick;
   logic [31:0]   rd_val;
   logic [31:0]   rd_q;

   logic          wr_time_lo, wr_time_hi, wr_cmp_lo, wr_cmp_hi;
   logic          unused_addr_bits;

   // Byte-lane merge of new write data over the old register word.
   function automatic logic [31:0] merge(input logic [31:0] old_w,
                                         input logic [31:0] new_w,
                                         input logic [3:0]  be);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

   assign sel              = i_bus_en && (i_addr[31:4] == BASE_ADDR[31:4]);
   assign unused_addr_bits = &{1'b0, i_addr[1:0]};

   // FSM state and wait counter register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Next state; commit marks the edge that enters ACK. With zero wait
   // states that is the accept edge itself, so the live bus fields are used.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      commit       = 1'b0;
      cmt_off      = lat_off;
      cmt_wr       = lat_wr;
      cmt_data     = lat_data;
      cmt_be       = lat_be;
      case (state)
         ST_IDLE: begin
            if (sel) begin
               cmt_off  = i_addr[3:2];
               cmt_wr   = i_wr_en;
               cmt_data = i_wr_data;
               cmt_be   = i_byte_en;
               if (WAIT_STATES == 0) begin
                  state_nxt = ST_ACK;
                  commit    = 1'b1;
               end else begin
                  state_nxt    = ST_WAIT;
                  wait_cnt_nxt = WS_M1;
               end
            end
         end
         ST_WAIT: begin
            if (wait_cnt == 4'd0) begin
               state_nxt = ST_ACK;
               commit    = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt - 4'd1;
            end
         end
         ST_ACK:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Capture the request fields when a selected request is accepted.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         lat_off  <= 2'd0;
         lat_wr   <= 1'b0;
         lat_data <= 32'd0;
         lat_be   <= 4'd0;
      end else if (state == ST_IDLE && sel) begin
         lat_off  <= i_addr[3:2];
         lat_wr   <= i_wr_en;
         lat_data <= i_wr_data;
         lat_be   <= i_byte_en;
      end
   end

   assign wr_time_lo = commit && cmt_wr && (cmt_off == 2'd0);
   assign wr_time_hi = commit && cmt_wr && (cmt_off == 2'd1);
   assign wr_cmp_lo  = commit && cmt_wr && (cmt_off == 2'd2);
   assign wr_cmp_hi  = commit && cmt_wr && (cmt_off == 2'd3);

   assign tick = (pre_cnt == PRE_MAX);

   // Prescaler: counts 0..PRESCALE-1, mtime advances on the wrap.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)     pre_cnt <= '0;
      else if (tick) pre_cnt <= '0;
      else           pre_cnt <= pre_cnt + 1'b1;
   end

   // mtime: a write to either half suppresses that cycle's increment.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         mtime <= 64'd0;
      end else if (wr_time_lo || wr_time_hi) begin
         if (wr_time_lo) mtime[31:0]  <= merge(mtime[31:0],  cmt_data, cmt_be);
         if (wr_time_hi) mtime[63:32] <= merge(mtime[63:32], cmt_data, cmt_be);
      end else if (tick) begin
         mtime <= mtime + 64'd1;
      end
   end

   // mtimecmp: plain byte-enabled register halves.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      end else begin
         if (wr_cmp_lo) mtimecmp[31:0]  <= merge(mtimecmp[31:0],  cmt_data, cmt_be);
         if (wr_cmp_hi) mtimecmp[63:32] <= merge(mtimecmp[63:32], cmt_data, cmt_be);
      end
   end

   // Read mux on the pre-edge register values.
   always_comb begin
      rd_val = 32'd0;
      case (cmt_off)
         2'd0:    rd_val = mtime[31:0];
         2'd1:    rd_val = mtime[63:32];
         2'd2:    rd_val = mtimecmp[31:0];
         default: rd_val = mtimecmp[63:32];
      endcase
   end

   // Read data is loaded on the edge entering ACK and cleared afterwards.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                 rd_q <= 32'd0;
      else if (commit && !cmt_wr) rd_q <= rd_val;
      else                       rd_q <= 32'd0;
   end

   // Timer interrupt: registered unsigned compare.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) o_tip <= 1'b0;
      else       o_tip <= (mtime >= mtimecmp);
   end

   assign o_ack     = (state == ST_ACK);
   assign o_rd_data = rd_q;
   assign o_state   = state;

endmodule

// File: tb/tb_bus_timer_slave.sv
// Directed bench for bus_timer_slave: one instance with no wait states,
// one with three wait states, both with PRESCALE=1.
module tb_bus_timer_slave;

   localparam logic [31:0] BASE = 32'h0200_0000;

   logic        clk;
   logic        rst     [2];
   logic        bus_en  [2];
   logic        wr_en   [2];
   logic [31:0] addr    [2];
   logic [31:0] wdata   [2];
   logic [3:0]  be      [2];
   logic        ack     [2];
   logic [31:0] rdata   [2];
   logic        tip     [2];
   logic [1:0]  st      [2];

   int          n_total;
   int          n_bad;
   logic [31:0] exp_q[$];

   bus_timer_slave #(.BASE_ADDR(BASE), .WAIT_STATES(0), .PRESCALE(1)) dut0 (
      .i_clk(clk), .i_rst(rst[0]), .i_bus_en(bus_en[0]), .i_wr_en(wr_en[0]),
      .i_addr(addr[0]), .i_wr_data(wdata[0]), .i_byte_en(be[0]),
      .o_ack(ack[0]), .o_rd_data(rdata[0]), .o_tip(tip[0]), .o_state(st[0])
   );

   bus_timer_slave #(.BASE_ADDR(BASE), .WAIT_STATES(3), .PRESCALE(1)) dut3 (
      .i_clk(clk), .i_rst(rst[1]), .i_bus_en(bus_en[1]), .i_wr_en(wr_en[1]),
      .i_addr(addr[1]), .i_wr_data(wdata[1]), .i_byte_en(be[1]),
      .o_ack(ack[1]), .o_rd_data(rdata[1]), .o_tip(tip[1]), .o_state(st[1])
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick1();
      @(posedge clk);
      #1;
   endtask

   // One bus transfer; returns read data and edges from request to ack.
   task automatic xfer(input int d, input logic w, input logic [31:0] a,
                       input logic [31:0] dat, input logic [3:0] b,
                       output logic [31:0] rd, output int lat);
      bus_en[d] = 1'b1; wr_en[d] = w; addr[d] = a; wdata[d] = dat; be[d] = b;
      lat = 0;
      rd  = 32'd0;
      while (lat < 40) begin
         tick1();
         lat++;
         if (ack[d]) break;
      end
      check("ack_seen", {63'd0, ack[d]}, 64'd1);
      rd = rdata[d];
      tick1();
      bus_en[d] = 1'b0; wr_en[d] = 1'b0;
   endtask

   task automatic wr(input int d, input logic [31:0] off, input logic [31:0] dat, input logic [3:0] b);
      logic [31:0] rd;
      int          lat;
      xfer(d, 1'b1, BASE + off, dat, b, rd, lat);
   endtask

   // Read and compare against the head of the expected queue.
   task automatic rd_chk(input int d, input logic [31:0] off, input string tag);
      logic [31:0] rd;
      int          lat;
      logic [31:0] exp;
      xfer(d, 1'b0, BASE + off, 32'd0, 4'h0, rd, lat);
      exp = exp_q.pop_front();
      check(tag, {32'd0, rd}, {32'd0, exp});
   endtask

   initial begin
      logic [31:0] rd;
      int          lat;
      int          acks;

      n_total = 0;
      n_bad   = 0;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; bus_en[i] = 1'b0; wr_en[i] = 1'b0;
         addr[i] = 32'd0; wdata[i] = 32'd0; be[i] = 4'h0;
      end

      // Reset values.
      repeat (3) tick1();
      for (int i = 0; i < 2; i++) begin
         check("rst_ack",   {63'd0, ack[i]}, 64'd0);
         check("rst_rdata", {32'd0, rdata[i]}, 64'd0);
         check("rst_tip",   {63'd0, tip[i]}, 64'd0);
         check("rst_state", {62'd0, st[i]}, 64'd0);
      end
      rst[0] = 1'b0; rst[1] = 1'b0;

      // First read of mtime low, accepted on the third edge after release.
      repeat (2) tick1();
      xfer(0, 1'b0, BASE + 32'h0, 32'd0, 4'h0, rd, lat);
      check("rd0_lat", 64'(lat), 64'd1);
      check("rd0_val", {32'd0, rd}, 64'd2);
      check("rd0_clear", {32'd0, rdata[0]}, 64'd0);
      exp_q.push_back(32'hFFFF_FFFF);
      rd_chk(0, 32'hC, "rst_cmp_hi");

      // Compare at 16: tip rises one cycle after mtime reaches 16.
      wr(0, 32'h8, 32'h0000_0010, 4'hF);
      wr(0, 32'hC, 32'h0000_0000, 4'hF);
      check("tip_pre", {63'd0, tip[0]}, 64'd0);
      wr(0, 32'h0, 32'h0000_0000, 4'hF);
      check("tip_e1", {63'd0, tip[0]}, 64'd0);
      for (int k = 2; k <= 19; k++) begin
         tick1();
         check($sformatf("tip_e%0d", k), {63'd0, tip[0]}, (k >= 17) ? 64'd1 : 64'd0);
      end

      // Byte-lane write on mtimecmp low.
      wr(0, 32'h8, 32'h1111_1111, 4'hF);
      wr(0, 32'h8, 32'hAABB_CCDD, 4'b0010);
      exp_q.push_back(32'h1111_CC11);
      rd_chk(0, 32'h8, "byte_wr");

      // Back-to-back reads: ack, idle, ack, idle.
      bus_en[0] = 1'b1; wr_en[0] = 1'b0; addr[0] = BASE + 32'h8;
      for (int i = 0; i < 4; i++) begin
         tick1();
         check($sformatf("b2b_ack%0d", i), {63'd0, ack[0]}, (i % 2 == 0) ? 64'd1 : 64'd0);
         check($sformatf("b2b_rd%0d", i), {32'd0, rdata[0]}, (i % 2 == 0) ? 64'h1111_CC11 : 64'd0);
         if (i == 2) bus_en[0] = 1'b0;
      end

      // Out-of-window access is never acked and changes nothing.
      bus_en[0] = 1'b1; wr_en[0] = 1'b1; addr[0] = BASE + 32'h18;
      wdata[0] = 32'h0; be[0] = 4'hF;
      acks = 0;
      for (int i = 0; i < 20; i++) begin
         tick1();
         if (ack[0]) acks++;
      end
      check("unsel_acks", 64'(acks), 64'd0);
      check("unsel_state", {62'd0, st[0]}, 64'd0);
      bus_en[0] = 1'b0; wr_en[0] = 1'b0;
      exp_q.push_back(32'h1111_CC11);
      rd_chk(0, 32'h8, "unsel_cmp");

      // mtime wrap from all-ones to zero.
      wr(0, 32'h4, 32'hFFFF_FFFF, 4'hF);
      wr(0, 32'h0, 32'hFFFF_FFFF, 4'hF);
      exp_q.push_back(32'h0000_0000);
      rd_chk(0, 32'h0, "wrap_lo");
      exp_q.push_back(32'h0000_0000);
      rd_chk(0, 32'h4, "wrap_hi");

      // Write colliding with an increment stores exactly, then counts on.
      wr(0, 32'h0, 32'h0000_0100, 4'hF);
      exp_q.push_back(32'h0000_0101);
      rd_chk(0, 32'h0, "collide_lo");
      exp_q.push_back(32'h0000_0000);
      rd_chk(0, 32'h4, "collide_hi");

      // Three wait states: ack four edges after the request.
      xfer(1, 1'b1, BASE + 32'hC, 32'h0000_ABCD, 4'hF, rd, lat);
      check("ws3_wr_lat", 64'(lat), 64'd4);
      xfer(1, 1'b0, BASE + 32'hC, 32'd0, 4'h0, rd, lat);
      check("ws3_rd_lat", 64'(lat), 64'd4);
      check("ws3_rd_val", {32'd0, rd}, 64'h0000_ABCD);

      // Reset during WAIT of a write: lost, no ack, back to IDLE.
      bus_en[1] = 1'b1; wr_en[1] = 1'b1; addr[1] = BASE + 32'h8;
      wdata[1] = 32'h1234_5678; be[1] = 4'hF;
      tick1();
      check("ws3_in_wait", {62'd0, st[1]}, 64'd1);
      rst[1] = 1'b1;
      #1;
      check("mid_rst_state", {62'd0, st[1]}, 64'd0);
      bus_en[1] = 1'b0; wr_en[1] = 1'b0;
      acks = 0;
      for (int i = 0; i < 3; i++) begin
         tick1();
         if (ack[1]) acks++;
      end
      rst[1] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick1();
         if (ack[1]) acks++;
      end
      check("mid_rst_acks", 64'(acks), 64'd0);
      exp_q.push_back(32'hFFFF_FFFF);
      rd_chk(1, 32'h8, "mid_rst_cmp_lo");
      exp_q.push_back(32'hFFFF_FFFF);
      rd_chk(1, 32'hC, "mid_rst_cmp_hi");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
